// File: rtl/atm_multi_acct_ctrl.sv
// Purpose : multi-account ATM session controller (card -> PIN -> menu -> amount -> exec -> report)
//           with per-account PIN-retry lockout and in-register balances/PINs.
// Latency : o_done rises 1 cycle after the deciding strobe, 2 cycles for paths through S_EXEC.
// Backpressure: none; strobes are single-cycle and only the strobe owned by the current state is used.
// Ports   : clk/rst (async active-low); i_card/i_acct, i_pin_vld/i_pin, i_menu_vld/i_menu,
//           i_amt_vld/i_amt/i_dst, i_cont_vld/i_cont, i_cancel in; o_busy, o_pin_req, o_done,
//           o_err, o_bal, o_locked out.
// Config  : define ATM_TIMEOUT_EN to enable the TIMEOUT_CYC inactivity timeout (err 6).
module atm_multi_acct_ctrl #(
    parameter int               BAL_W     = 16,
    parameter int               NUM_ACCT  = 4,
    parameter int               PIN_W     = 16,
    parameter int               MAX_TRIES = 3,
    parameter int unsigned      INIT_BAL  = 100,
    parameter logic [PIN_W-1:0] INIT_PIN  = 16'h1111
`ifdef ATM_TIMEOUT_EN
    , parameter int             TIMEOUT_CYC = 1024
`endif
    , localparam int            ACCT_W    = (NUM_ACCT > 1) ? $clog2(NUM_ACCT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_card,
    input  logic [ACCT_W-1:0]   i_acct,
    input  logic                i_pin_vld,
    input  logic [PIN_W-1:0]    i_pin,
    input  logic                i_menu_vld,
    input  logic [2:0]          i_menu,
    input  logic                i_amt_vld,
    input  logic [BAL_W-1:0]    i_amt,
    input  logic [ACCT_W-1:0]   i_dst,
    input  logic                i_cont_vld,
    input  logic                i_cont,
    input  logic                i_cancel,
    output logic                o_busy,
    output logic                o_pin_req,
    output logic                o_done,
    output logic [2:0]          o_err,
    output logic [BAL_W-1:0]    o_bal,
    output logic [NUM_ACCT-1:0] o_locked
);

    typedef enum logic [2:0] {S_IDLE, S_PIN, S_MENU, S_AMT, S_EXEC, S_REPORT} state_t;

    localparam logic [2:0] OP_DEP  = 3'b001;
    localparam logic [2:0] OP_WDR  = 3'b010;
    localparam logic [2:0] OP_BAL  = 3'b011;
    localparam logic [2:0] OP_XFER = 3'b100;
    localparam logic [2:0] OP_PIN  = 3'b101;

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_BADPIN  = 3'd1;
    localparam logic [2:0] ERR_LOCKED  = 3'd2;
    localparam logic [2:0] ERR_FUNDS   = 3'd3;
    localparam logic [2:0] ERR_OVF     = 3'd4;
    localparam logic [2:0] ERR_BADDST  = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;
    localparam logic [2:0] ERR_BADMENU = 3'd7;

    localparam logic [BAL_W-1:0]  INIT_BAL_V = BAL_W'(INIT_BAL);
    localparam logic [2:0]        MAX_T_V    = 3'(MAX_TRIES);
    localparam logic [ACCT_W:0]   NUM_ACCT_V = (ACCT_W + 1)'(NUM_ACCT);

    state_t                state_q, state_d;
    logic [ACCT_W-1:0]     acct_q, acct_d;
    logic [2:0]            op_q, op_d;
    logic [BAL_W-1:0]      amt_q, amt_d;
    logic [ACCT_W-1:0]     dst_q, dst_d;
    logic [PIN_W-1:0]      npin_q, npin_d;
    logic [BAL_W-1:0]      bal_q  [NUM_ACCT];
    logic [BAL_W-1:0]      bal_d  [NUM_ACCT];
    logic [PIN_W-1:0]      pin_q  [NUM_ACCT];
    logic [PIN_W-1:0]      pin_d  [NUM_ACCT];
    logic [2:0]            fail_q [NUM_ACCT];
    logic [2:0]            fail_d [NUM_ACCT];
    logic [NUM_ACCT-1:0]   locked_q, locked_d;
    logic                  done_q, done_d;
    logic [2:0]            err_q, err_d;
    logic [BAL_W-1:0]      obal_q, obal_d;
    // Set while the current report follows a wrong PIN, so i_cont=1 goes back to S_PIN.
    logic                  retry_q, retry_d;

    logic [BAL_W:0]        sum_w;
    logic [BAL_W:0]        dsum_w;
    logic [2:0]            fail_inc;
    logic                  tmo_fire;

`ifdef ATM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        acct_d   = acct_q;
        op_d     = op_q;
        amt_d    = amt_q;
        dst_d    = dst_q;
        npin_d   = npin_q;
        bal_d    = bal_q;
        pin_d    = pin_q;
        fail_d   = fail_q;
        locked_d = locked_q;
        err_d    = err_q;
        obal_d   = obal_q;
        retry_d  = retry_q;
        sum_w    = '0;
        dsum_w   = '0;
        fail_inc = fail_q[acct_q] + 3'd1;
        tmo_fire = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_card) begin
                    acct_d  = i_acct;
                    retry_d = 1'b0;
                    if (locked_q[i_acct]) begin
                        state_d = S_REPORT;
                        err_d   = ERR_LOCKED;
                        obal_d  = bal_q[i_acct];
                    end else begin
                        state_d = S_PIN;
                    end
                end
            end
            S_PIN: begin
                if (i_cancel) begin
                    state_d = S_IDLE;
                end else if (i_pin_vld) begin
                    if (i_pin == pin_q[acct_q]) begin
                        fail_d[acct_q] = 3'd0;
                        state_d        = S_MENU;
                    end else begin
                        fail_d[acct_q] = fail_inc;
                        state_d        = S_REPORT;
                        obal_d         = bal_q[acct_q];
                        if (fail_inc >= MAX_T_V) begin
                            locked_d[acct_q] = 1'b1;
                            err_d            = ERR_LOCKED;
                        end else begin
                            err_d   = ERR_BADPIN;
                            retry_d = 1'b1;
                        end
                    end
                end
            end
            S_MENU: begin
                if (i_cancel) begin
                    state_d = S_IDLE;
                end else if (i_menu_vld) begin
                    op_d = i_menu;
                    case (i_menu)
                        OP_BAL:                          state_d = S_EXEC;
                        OP_DEP, OP_WDR, OP_XFER, OP_PIN: state_d = S_AMT;
                        default: begin
                            state_d = S_REPORT;
                            err_d   = ERR_BADMENU;
                            obal_d  = bal_q[acct_q];
                        end
                    endcase
                end
            end
            S_AMT: begin
                if (i_cancel) begin
                    state_d = S_IDLE;
                end else if (i_amt_vld) begin
                    amt_d   = i_amt;
                    dst_d   = i_dst;
                    npin_d  = i_pin;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Always completes; i_cancel is deliberately not looked at here.
                state_d = S_REPORT;
                err_d   = ERR_OK;
                obal_d  = bal_q[acct_q];
                case (op_q)
                    OP_DEP: begin
                        sum_w = {1'b0, bal_q[acct_q]} + {1'b0, amt_q};
                        if (sum_w[BAL_W]) begin
                            err_d = ERR_OVF;
                        end else begin
                            bal_d[acct_q] = sum_w[BAL_W-1:0];
                            obal_d        = sum_w[BAL_W-1:0];
                        end
                    end
                    OP_WDR: begin
                        if (amt_q > bal_q[acct_q]) begin
                            err_d = ERR_FUNDS;
                        end else begin
                            bal_d[acct_q] = bal_q[acct_q] - amt_q;
                            obal_d        = bal_q[acct_q] - amt_q;
                        end
                    end
                    OP_XFER: begin
                        // Error precedence: bad destination, then funds, then destination overflow.
                        if ((dst_q == acct_q) || ({1'b0, dst_q} >= NUM_ACCT_V)) begin
                            err_d = ERR_BADDST;
                        end else if (amt_q > bal_q[acct_q]) begin
                            err_d = ERR_FUNDS;
                        end else begin
                            dsum_w = {1'b0, bal_q[dst_q]} + {1'b0, amt_q};
                            if (dsum_w[BAL_W]) begin
                                err_d = ERR_OVF;
                            end else begin
                                bal_d[acct_q] = bal_q[acct_q] - amt_q;
                                bal_d[dst_q]  = dsum_w[BAL_W-1:0];
                                obal_d        = bal_q[acct_q] - amt_q;
                            end
                        end
                    end
                    OP_PIN:  pin_d[acct_q] = npin_q;
                    OP_BAL:  ;
                    default: err_d = ERR_BADMENU;
                endcase
            end
            S_REPORT: begin
                if (i_cancel) begin
                    state_d = S_IDLE;
                end else if ((err_q == ERR_LOCKED) || (err_q == ERR_TIMEOUT)) begin
                    // Lockout/timeout reports close the session by themselves.
                    state_d = S_IDLE;
                end else if (i_cont_vld) begin
                    retry_d = 1'b0;
                    if (i_cont) begin
                        state_d = retry_q ? S_PIN : S_MENU;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ATM_TIMEOUT_EN
        // Timeout only fires when nothing else moved the FSM this cycle.
        if ((state_d == state_q) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) &&
            ((state_q == S_PIN) || (state_q == S_MENU) ||
             (state_q == S_AMT) || (state_q == S_REPORT))) begin
            tmo_fire = 1'b1;
            state_d  = S_REPORT;
            err_d    = ERR_TIMEOUT;
            obal_d   = bal_q[acct_q];
            retry_d  = 1'b0;
        end
        tmo_d = (state_d != state_q) ? '0 :
                (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) ? tmo_q : tmo_q + 1'b1;
`endif

        done_d = (state_d == S_REPORT) && ((state_q != S_REPORT) || tmo_fire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            acct_q   <= '0;
            op_q     <= '0;
            amt_q    <= '0;
            dst_q    <= '0;
            npin_q   <= '0;
            for (int i = 0; i < NUM_ACCT; i++) begin
                bal_q[i]  <= INIT_BAL_V;
                pin_q[i]  <= INIT_PIN;
                fail_q[i] <= 3'd0;
            end
            locked_q <= '0;
            done_q   <= 1'b0;
            err_q    <= ERR_OK;
            obal_q   <= '0;
            retry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acct_q   <= acct_d;
            op_q     <= op_d;
            amt_q    <= amt_d;
            dst_q    <= dst_d;
            npin_q   <= npin_d;
            bal_q    <= bal_d;
            pin_q    <= pin_d;
            fail_q   <= fail_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            err_q    <= err_d;
            obal_q   <= obal_d;
            retry_q  <= retry_d;
        end
    end

`ifdef ATM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign o_busy    = (state_q != S_IDLE);
    assign o_pin_req = (state_q == S_PIN);
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_bal     = obal_q;
    assign o_locked  = locked_q;

endmodule

// File: tb/tb_atm_multi_acct_ctrl.sv
// Purpose : directed self-checking bench for atm_multi_acct_ctrl (default build, no timeout).
// Latency : outputs sampled 1 time unit after each rising edge; strobes last one cycle.
// Backpressure: n/a; a second instance with NUM_ACCT=3 exercises the out-of-range destination.
module tb_atm_multi_acct_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        card = 1'b0, b_card = 1'b0;
    logic [1:0]  acct = '0;
    logic        pin_vld = 1'b0;
    logic [15:0] pin = '0;
    logic        menu_vld = 1'b0;
    logic [2:0]  menu = '0;
    logic        amt_vld = 1'b0;
    logic [15:0] amt = '0;
    logic [1:0]  dst = '0;
    logic        cont_vld = 1'b0;
    logic        cont = 1'b0;
    logic        cancel = 1'b0;

    logic        busy, pin_req, done;
    logic [2:0]  err;
    logic [15:0] bal;
    logic [3:0]  locked;
    logic        b_busy, b_pin_req, b_done;
    logic [2:0]  b_err;
    logic [15:0] b_bal;
    logic [2:0]  b_locked;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    atm_multi_acct_ctrl u_dut (
        .clk(clk), .rst(rst), .i_card(card), .i_acct(acct),
        .i_pin_vld(pin_vld), .i_pin(pin), .i_menu_vld(menu_vld), .i_menu(menu),
        .i_amt_vld(amt_vld), .i_amt(amt), .i_dst(dst),
        .i_cont_vld(cont_vld), .i_cont(cont), .i_cancel(cancel),
        .o_busy(busy), .o_pin_req(pin_req), .o_done(done), .o_err(err),
        .o_bal(bal), .o_locked(locked)
    );

    atm_multi_acct_ctrl #(.NUM_ACCT(3)) u_b (
        .clk(clk), .rst(rst), .i_card(b_card), .i_acct(acct),
        .i_pin_vld(pin_vld), .i_pin(pin), .i_menu_vld(menu_vld), .i_menu(menu),
        .i_amt_vld(amt_vld), .i_amt(amt), .i_dst(dst),
        .i_cont_vld(cont_vld), .i_cont(cont), .i_cancel(cancel),
        .o_busy(b_busy), .o_pin_req(b_pin_req), .o_done(b_done), .o_err(b_err),
        .o_bal(b_bal), .o_locked(b_locked)
    );

    // Stimulus drivers: each is entered and left 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic s_card(input logic [1:0] a);
        card = 1'b1; acct = a; tick(); card = 1'b0;
    endtask
    task automatic s_bcard(input logic [1:0] a);
        b_card = 1'b1; acct = a; tick(); b_card = 1'b0;
    endtask
    task automatic s_pin(input logic [15:0] p);
        pin_vld = 1'b1; pin = p; tick(); pin_vld = 1'b0;
    endtask
    task automatic s_menu(input logic [2:0] m);
        menu_vld = 1'b1; menu = m; tick(); menu_vld = 1'b0;
    endtask
    task automatic s_amt(input logic [15:0] a, input logic [1:0] d, input logic [15:0] np);
        amt_vld = 1'b1; amt = a; dst = d; pin = np; tick(); amt_vld = 1'b0;
    endtask
    task automatic s_cont(input logic c);
        cont_vld = 1'b1; cont = c; tick(); cont_vld = 1'b0;
    endtask
    task automatic s_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(); tick();
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rst_busy act=%0b exp=0", busy); end
        checks++; if (pin_req !== 1'b0)  begin failures++; $display("FAIL rst_pin_req act=%0b exp=0", pin_req); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL rst_done act=%0b exp=0", done); end
        checks++; if (err !== 3'd0)      begin failures++; $display("FAIL rst_err act=%0d exp=0", err); end
        checks++; if (bal !== 16'd0)     begin failures++; $display("FAIL rst_bal act=%0d exp=0", bal); end
        checks++; if (locked !== 4'h0)   begin failures++; $display("FAIL rst_locked act=%b exp=0000", locked); end
        rst = 1'b1; tick();
    endtask

    task automatic test_deposit();
        s_card(2'd0);
        checks++; if (pin_req !== 1'b1) begin failures++; $display("FAIL dep_pin_req act=%0b exp=1", pin_req); end
        s_pin(16'h1111);
        checks++; if (pin_req !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL dep_menu_state pin_req=%0b busy=%0b exp 0/1", pin_req, busy); end
        s_menu(3'b001);
        s_amt(16'd50, 2'd0, 16'h0);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL dep_done_early act=%0b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL dep_done act=%0b exp=1", done); end
        checks++; if (err !== 3'd0)  begin failures++; $display("FAIL dep_err act=%0d exp=0", err); end
        checks++; if (bal !== 16'd150) begin failures++; $display("FAIL dep_bal act=%0d exp=150", bal); end
        tick();
        checks++; if (done !== 1'b0 || bal !== 16'd150) begin failures++; $display("FAIL dep_hold done=%0b bal=%0d exp 0/150", done, bal); end
        s_cont(1'b0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dep_end_busy act=%0b exp=0", busy); end
    endtask

    task automatic test_withdraw();
        s_card(2'd1); s_pin(16'h1111);
        s_menu(3'b010); s_amt(16'd101, 2'd0, 16'h0); tick();
        checks++; if (err !== 3'd3 || bal !== 16'd100) begin failures++; $display("FAIL wdr_funds err=%0d bal=%0d exp 3/100", err, bal); end
        tick();
        checks++; if (err !== 3'd3 || done !== 1'b0) begin failures++; $display("FAIL wdr_err_held err=%0d done=%0b exp 3/0", err, done); end
        s_cont(1'b1);
        s_menu(3'b010); s_amt(16'd100, 2'd0, 16'h0); tick();
        checks++; if (err !== 3'd0 || bal !== 16'd0) begin failures++; $display("FAIL wdr_exact err=%0d bal=%0d exp 0/0", err, bal); end
        s_cont(1'b1);
        s_menu(3'b001); s_amt(16'd1, 2'd0, 16'h0); tick();
        s_cont(1'b1);
        s_menu(3'b001); s_amt(16'hFFFF, 2'd0, 16'h0); tick();
        checks++; if (err !== 3'd4 || bal !== 16'd1) begin failures++; $display("FAIL dep_ovf err=%0d bal=%0d exp 4/1", err, bal); end
        s_cont(1'b0);
    endtask

    task automatic test_transfer();
        do_reset();
        s_card(2'd1); s_pin(16'h1111);
        s_menu(3'b100); s_amt(16'd30, 2'd2, 16'h0); tick();
        checks++; if (err !== 3'd0 || bal !== 16'd70) begin failures++; $display("FAIL xfer_ok err=%0d bal=%0d exp 0/70", err, bal); end
        s_cont(1'b1);
        s_menu(3'b100); s_amt(16'd5, 2'd1, 16'h0); tick();
        checks++; if (err !== 3'd5 || bal !== 16'd70) begin failures++; $display("FAIL xfer_self err=%0d bal=%0d exp 5/70", err, bal); end
        s_cont(1'b1);
        s_menu(3'b100); s_amt(16'd71, 2'd2, 16'h0); tick();
        checks++; if (err !== 3'd3 || bal !== 16'd70) begin failures++; $display("FAIL xfer_funds err=%0d bal=%0d exp 3/70", err, bal); end
        s_cont(1'b0);
        s_card(2'd2); s_pin(16'h1111); s_menu(3'b011); tick();
        checks++; if (err !== 3'd0 || bal !== 16'd130) begin failures++; $display("FAIL xfer_dst_bal err=%0d bal=%0d exp 0/130", err, bal); end
        s_cont(1'b1);
        s_menu(3'b001); s_amt(16'd65405, 2'd0, 16'h0); tick();
        checks++; if (err !== 3'd0 || bal !== 16'hFFFF) begin failures++; $display("FAIL dep_to_max err=%0d bal=%0d exp 0/65535", err, bal); end
        s_cont(1'b0);
        s_card(2'd1); s_pin(16'h1111);
        s_menu(3'b100); s_amt(16'd1, 2'd2, 16'h0); tick();
        checks++; if (err !== 3'd4 || bal !== 16'd70) begin failures++; $display("FAIL xfer_dst_ovf err=%0d bal=%0d exp 4/70", err, bal); end
        s_cont(1'b0);
    endtask

    task automatic test_dst_range();
        s_bcard(2'd0); s_pin(16'h1111);
        s_menu(3'b100); s_amt(16'd10, 2'd3, 16'h0); tick();
        checks++; if (b_done !== 1'b1 || b_err !== 3'd5 || b_bal !== 16'd100) begin failures++; $display("FAIL xfer_range done=%0b err=%0d bal=%0d exp 1/5/100", b_done, b_err, b_bal); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_ignores_strobes busy=%0b exp=0", busy); end
        s_cont(1'b1);
        s_menu(3'b100); s_amt(16'd10, 2'd2, 16'h0); tick();
        checks++; if (b_err !== 3'd0 || b_bal !== 16'd90) begin failures++; $display("FAIL xfer_n3_ok err=%0d bal=%0d exp 0/90", b_err, b_bal); end
        s_cont(1'b0);
    endtask

    task automatic test_pin_change();
        s_card(2'd2); s_pin(16'h1111);
        s_menu(3'b101); s_amt(16'd0, 2'd0, 16'h2222); tick();
        checks++; if (err !== 3'd0 || bal !== 16'hFFFF) begin failures++; $display("FAIL pinchg err=%0d bal=%0d exp 0/65535", err, bal); end
        s_cont(1'b0);
        s_card(2'd2); s_pin(16'h1111);
        checks++; if (done !== 1'b1 || err !== 3'd1) begin failures++; $display("FAIL old_pin done=%0b err=%0d exp 1/1", done, err); end
        s_cont(1'b1);
        checks++; if (pin_req !== 1'b1) begin failures++; $display("FAIL retry_to_pin act=%0b exp=1", pin_req); end
        s_pin(16'h2222);
        checks++; if (pin_req !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL new_pin pin_req=%0b busy=%0b exp 0/1", pin_req, busy); end
        s_menu(3'b110);
        checks++; if (done !== 1'b1 || err !== 3'd7) begin failures++; $display("FAIL badmenu done=%0b err=%0d exp 1/7", done, err); end
        s_cont(1'b0);
    endtask

    task automatic test_lockout();
        s_card(2'd3); s_pin(16'h0000);
        checks++; if (err !== 3'd1 || locked !== 4'h0) begin failures++; $display("FAIL lock_try1 err=%0d locked=%b exp 1/0000", err, locked); end
        s_cont(1'b1); s_pin(16'h0000);
        checks++; if (err !== 3'd1) begin failures++; $display("FAIL lock_try2 err=%0d exp=1", err); end
        s_cont(1'b1); s_pin(16'h0000);
        checks++; if (done !== 1'b1 || err !== 3'd2 || locked !== 4'b1000) begin failures++; $display("FAIL lock_try3 done=%0b err=%0d locked=%b exp 1/2/1000", done, err, locked); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lock_auto_idle busy=%0b exp=0", busy); end
        s_card(2'd3);
        checks++; if (done !== 1'b1 || err !== 3'd2 || pin_req !== 1'b0) begin failures++; $display("FAIL locked_card done=%0b err=%0d pin_req=%0b exp 1/2/0", done, err, pin_req); end
        tick();
        // A correct PIN clears the count, so two later misses on acct0 stay at BADPIN.
        s_card(2'd0); s_pin(16'h0000); s_cont(1'b1); s_pin(16'h1111); s_cancel();
        s_card(2'd0); s_pin(16'h0000); s_cont(1'b1); s_pin(16'h0000);
        checks++; if (err !== 3'd1 || locked !== 4'b1000) begin failures++; $display("FAIL fail_cnt_clear err=%0d locked=%b exp 1/1000", err, locked); end
        s_cont(1'b0);
    endtask

    task automatic test_cancel();
        s_card(2'd1); s_pin(16'h1111); s_menu(3'b010);
        amt_vld = 1'b1; amt = 16'd10; cancel = 1'b1; tick(); amt_vld = 1'b0; cancel = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL cancel_amt busy=%0b done=%0b exp 0/0", busy, done); end
        s_card(2'd1); s_pin(16'h1111); s_menu(3'b011); tick();
        checks++; if (err !== 3'd0 || bal !== 16'd70) begin failures++; $display("FAIL cancel_no_change err=%0d bal=%0d exp 0/70", err, bal); end
        s_cont(1'b0);
    endtask

    task automatic test_reset_mid_exec();
        s_card(2'd0); s_pin(16'h1111); s_menu(3'b001); s_amt(16'd7, 2'd0, 16'h0);
        rst = 1'b0; #1;
        checks++; if (busy !== 1'b0 || locked !== 4'h0 || err !== 3'd0 || bal !== 16'd0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid busy=%0b locked=%b err=%0d bal=%0d done=%0b exp all 0", busy, locked, err, bal, done); end
        tick(); rst = 1'b1; tick();
        s_card(2'd3);
        checks++; if (pin_req !== 1'b1) begin failures++; $display("FAIL rst_unlock pin_req=%0b exp=1", pin_req); end
        s_pin(16'h1111); s_menu(3'b011); tick();
        checks++; if (err !== 3'd0 || bal !== 16'd100) begin failures++; $display("FAIL rst_bal_init err=%0d bal=%0d exp 0/100", err, bal); end
        s_cont(1'b0);
        s_card(2'd0); s_pin(16'h1111); s_menu(3'b011); tick();
        checks++; if (bal !== 16'd100) begin failures++; $display("FAIL rst_exec_dropped bal=%0d exp=100", bal); end
        s_cont(1'b0);
    endtask

    task automatic test_no_timeout();
        s_card(2'd0); s_pin(16'h1111);
        repeat (1000) tick();
        checks++; if (busy !== 1'b1 || pin_req !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL no_timeout busy=%0b pin_req=%0b done=%0b exp 1/0/0", busy, pin_req, done); end
        s_cancel();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_menu busy=%0b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_deposit();
        test_withdraw();
        test_transfer();
        test_dst_range();
        test_pin_change();
        test_lockout();
        test_cancel();
        test_reset_mid_exec();
        test_no_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
